freq_sig_gen: RTL and testbench



---
 rtl/freq_sig_gen.sv | 155 +++++++++++++++
 tb/tb_freq_sig_gen.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_sig_gen.sv
`default_nettype none
// ============================================================================
// freq_sig_gen : 32-bit DDS square-wave generator, continuous or N-period burst
// Option macro : FREQ_SIG_GEN_DUTY_EN (adds cfg_duty, programmable threshold)
// Revision     : 1.0
// ============================================================================
module freq_sig_gen #(
    parameter logic [31:0] TW_MAX = 32'h4000_0000
) (
    input  logic        clk_200M,
    input  logic        rst_n,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [31:0] cfg_tw,
    input  logic [31:0] cfg_burst,
`ifdef FREQ_SIG_GEN_DUTY_EN
    input  logic [31:0] cfg_duty,
`endif
    input  logic        start,
    input  logic        stop,
    output logic        sig_out,
    output logic        busy,
    output logic        done,
    output logic [31:0] pulse_cnt
);

    localparam logic [1:0]  c_IDLE    = 2'd0;
    localparam logic [1:0]  c_RUN     = 2'd1;
    localparam logic [1:0]  c_FINISH  = 2'd2;
    localparam logic [31:0] c_TH_HALF = 32'h8000_0000;

    logic [1:0]  state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] tw_q, tw_d;
    logic [31:0] burst_q, burst_d;
    logic [31:0] pulse_cnt_q, pulse_cnt_d;
    logic        sig_q, sig_d;
    logic        done_q, done_d;

    logic [31:0] w_th;
    logic [31:0] w_acc_next;
    logic [31:0] w_cnt_inc;
    logic        w_above;
    logic        w_rise_next;

`ifdef FREQ_SIG_GEN_DUTY_EN
    logic [31:0] duty_q, duty_d;
    assign w_th = (duty_q == 32'd0) ? c_TH_HALF : duty_q;
`else
    assign w_th = c_TH_HALF;
`endif

    assign w_above     = (acc_q >= w_th);
    assign w_rise_next = w_above && !sig_q;
    assign w_acc_next  = acc_q + tw_q;
    assign w_cnt_inc   = pulse_cnt_q + 32'd1;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        tw_d        = tw_q;
        burst_d     = burst_q;
        pulse_cnt_d = pulse_cnt_q;
        sig_d       = sig_q;
        done_d      = 1'b0;
`ifdef FREQ_SIG_GEN_DUTY_EN
        duty_d      = duty_q;
`endif
        case (state_q)
            c_IDLE: begin
                acc_d = 32'd0;
                sig_d = 1'b0;
                if (cfg_valid) begin
                    tw_d    = (cfg_tw > TW_MAX) ? TW_MAX : cfg_tw;
                    burst_d = cfg_burst;
`ifdef FREQ_SIG_GEN_DUTY_EN
                    duty_d  = cfg_duty;
`endif
                end
                if (start && !stop) begin
                    pulse_cnt_d = 32'd0;
                    state_d     = c_RUN;
                end
            end
            c_RUN, c_FINISH: begin
                if (state_q == c_RUN && stop && !sig_q) begin
                    // Stop while low: abort at once, a pending rise is dropped
                    sig_d   = 1'b0;
                    acc_d   = 32'd0;
                    done_d  = 1'b1;
                    state_d = c_IDLE;
                end else if (state_q == c_FINISH || stop) begin
                    // Wind-down: hold the high phase, end exactly on its falling edge
                    if (w_above) begin
                        acc_d   = w_acc_next;
                        state_d = c_FINISH;
                    end else begin
                        sig_d   = 1'b0;
                        acc_d   = 32'd0;
                        done_d  = 1'b1;
                        state_d = c_IDLE;
                    end
                end else begin
                    acc_d = w_acc_next;
                    sig_d = w_above;
                    if (w_rise_next) begin
                        pulse_cnt_d = w_cnt_inc;
                        if (burst_q != 32'd0 && w_cnt_inc == burst_q) begin
                            state_d = c_FINISH;
                        end
                    end
                end
            end
            default: begin
                sig_d   = 1'b0;
                acc_d   = 32'd0;
                state_d = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_200M or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= c_IDLE;
            acc_q       <= 32'd0;
            tw_q        <= 32'd0;
            burst_q     <= 32'd0;
            pulse_cnt_q <= 32'd0;
            sig_q       <= 1'b0;
            done_q      <= 1'b0;
`ifdef FREQ_SIG_GEN_DUTY_EN
            duty_q      <= 32'd0;
`endif
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            tw_q        <= tw_d;
            burst_q     <= burst_d;
            pulse_cnt_q <= pulse_cnt_d;
            sig_q       <= sig_d;
            done_q      <= done_d;
`ifdef FREQ_SIG_GEN_DUTY_EN
            duty_q      <= duty_d;
`endif
        end
    end

    assign sig_out   = sig_q;
    assign done      = done_q;
    assign pulse_cnt = pulse_cnt_q;
    assign busy      = (state_q == c_RUN) || (state_q == c_FINISH);
    assign cfg_ready = (state_q == c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_freq_sig_gen.sv
`default_nettype none
// ============================================================================
// tb_freq_sig_gen : scoreboard bench for freq_sig_gen (default build)
// Revision        : 1.0
// ============================================================================
module tb_freq_sig_gen;

    logic        clk_200M  = 1'b0;
    logic        rst_n     = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [31:0] cfg_tw    = 32'd0;
    logic [31:0] cfg_burst = 32'd0;
    logic        start     = 1'b0;
    logic        stop      = 1'b0;
    logic        cfg_ready;
    logic        sig_out;
    logic        busy;
    logic        done;
    logic [31:0] pulse_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        s;
        logic        d;
        logic        b;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];

    freq_sig_gen dut (
        .clk_200M  (clk_200M),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_tw    (cfg_tw),
        .cfg_burst (cfg_burst),
        .start     (start),
        .stop      (stop),
        .sig_out   (sig_out),
        .busy      (busy),
        .done      (done),
        .pulse_cnt (pulse_cnt)
    );

    always #5 clk_200M = ~clk_200M;

    // Ideal DDS output after edge Ek: MSB of the accumulator one edge earlier
    function automatic logic exp_sig(input logic [31:0] tw, input int k);
        logic [31:0] a;
        if (k < 1) return 1'b0;
        a = tw * 32'(k - 1);
        return a[31];
    endfunction

    // Expected trace for edges E0..E(last): ideal wave until done_k, then idle
    task automatic push_seq(input logic [31:0] tw, input int done_k, input int last);
        exp_t        e;
        logic        prev;
        logic [31:0] cnt;
        prev = 1'b0;
        cnt  = 32'd0;
        for (int k = 0; k <= last; k++) begin
            if (k < done_k) begin
                e.s = exp_sig(tw, k);
                e.b = 1'b1;
                e.d = 1'b0;
                if (e.s && !prev) cnt = cnt + 32'd1;
            end else begin
                e.s = 1'b0;
                e.b = 1'b0;
                e.d = (k == done_k);
            end
            e.pc = cnt;
            prev = e.s;
            sb.push_back(e);
        end
    endtask

    task automatic do_cfg(input logic [31:0] tw, input logic [31:0] burst);
        cfg_tw    = tw;
        cfg_burst = burst;
        cfg_valid = 1'b1;
        @(posedge clk_200M); #1;
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        n_tests++;
        if ({sig_out, busy, done, cfg_ready, pulse_cnt} !== {1'b0, 1'b0, 1'b0, 1'b1, 32'd0}) begin
            n_fail++;
            $display("FAIL reset_hold got sig/busy/done/rdy/cnt=%b/%b/%b/%b/%0d want 0/0/0/1/0",
                     sig_out, busy, done, cfg_ready, pulse_cnt);
        end
        @(negedge clk_200M);
        rst_n = 1'b1;
        @(posedge clk_200M); #1;
        do_cfg(32'h4000_0000, 32'd0);
        start = 1'b1;
        @(posedge clk_200M); #1;
        start = 1'b0;
        repeat (4) @(posedge clk_200M);
        #1;
        n_tests++;
        if ({sig_out, busy, pulse_cnt} !== {1'b1, 1'b1, 32'd1}) begin
            n_fail++;
            $display("FAIL reset_prerun got sig/busy/cnt=%b/%b/%0d want 1/1/1", sig_out, busy, pulse_cnt);
        end
        #1 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({sig_out, busy, done, pulse_cnt} !== {1'b0, 1'b0, 1'b0, 32'd0}) begin
            n_fail++;
            $display("FAIL reset_async got sig/busy/done/cnt=%b/%b/%b/%0d want 0/0/0/0",
                     sig_out, busy, done, pulse_cnt);
        end
        @(negedge clk_200M);
        rst_n = 1'b1;
        @(posedge clk_200M); #1;
        n_tests++;
        if ({cfg_ready, busy, sig_out} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_release got rdy/busy/sig=%b/%b/%b want 1/0/0", cfg_ready, busy, sig_out);
        end
    endtask

    task automatic test_burst();
        exp_t e;
        do_cfg(32'h4000_0000, 32'd3);
        push_seq(32'h4000_0000, 13, 14);
        for (int k = 0; k <= 14; k++) begin
            start = (k == 0);
            @(posedge clk_200M); #1;
            start = 1'b0;
            e = sb.pop_front();
            n_tests++;
            if ({sig_out, done, busy, cfg_ready, pulse_cnt} !== {e.s, e.d, e.b, ~e.b, e.pc}) begin
                n_fail++;
                $display("FAIL burst k=%0d got sig/done/busy/rdy/cnt=%b/%b/%b/%b/%0d want %b/%b/%b/%b/%0d",
                         k, sig_out, done, busy, cfg_ready, pulse_cnt, e.s, e.d, e.b, ~e.b, e.pc);
            end
        end
    endtask

    task automatic test_clamp();
        exp_t e;
        do_cfg(32'h8000_0000, 32'd0);
        push_seq(32'h4000_0000, 13, 13);
        for (int k = 0; k <= 13; k++) begin
            start = (k == 0);
            stop  = (k == 12);
            @(posedge clk_200M); #1;
            start = 1'b0;
            stop  = 1'b0;
            e = sb.pop_front();
            n_tests++;
            if ({sig_out, done, busy, cfg_ready, pulse_cnt} !== {e.s, e.d, e.b, ~e.b, e.pc}) begin
                n_fail++;
                $display("FAIL clamp k=%0d got sig/done/busy/rdy/cnt=%b/%b/%b/%b/%0d want %b/%b/%b/%b/%0d",
                         k, sig_out, done, busy, cfg_ready, pulse_cnt, e.s, e.d, e.b, ~e.b, e.pc);
            end
        end
    endtask

    task automatic test_stop();
        exp_t e;
        do_cfg(32'h1000_0000, 32'd0);
        push_seq(32'h1000_0000, 17, 18);
        for (int k = 0; k <= 18; k++) begin
            start = (k == 0);
            stop  = (k == 12);
            @(posedge clk_200M); #1;
            start = 1'b0;
            stop  = 1'b0;
            e = sb.pop_front();
            n_tests++;
            if ({sig_out, done, busy, cfg_ready, pulse_cnt} !== {e.s, e.d, e.b, ~e.b, e.pc}) begin
                n_fail++;
                $display("FAIL stop_high k=%0d got sig/done/busy/rdy/cnt=%b/%b/%b/%b/%0d want %b/%b/%b/%b/%0d",
                         k, sig_out, done, busy, cfg_ready, pulse_cnt, e.s, e.d, e.b, ~e.b, e.pc);
            end
        end
        // Stop lands on the edge where the first rise would otherwise occur
        push_seq(32'h1000_0000, 9, 10);
        for (int k = 0; k <= 10; k++) begin
            start = (k == 0);
            stop  = (k == 9);
            @(posedge clk_200M); #1;
            start = 1'b0;
            stop  = 1'b0;
            e = sb.pop_front();
            n_tests++;
            if ({sig_out, done, busy, cfg_ready, pulse_cnt} !== {e.s, e.d, e.b, ~e.b, e.pc}) begin
                n_fail++;
                $display("FAIL stop_low k=%0d got sig/done/busy/rdy/cnt=%b/%b/%b/%b/%0d want %b/%b/%b/%b/%0d",
                         k, sig_out, done, busy, cfg_ready, pulse_cnt, e.s, e.d, e.b, ~e.b, e.pc);
            end
        end
    endtask

    task automatic test_handshake();
        exp_t e;
        do_cfg(32'h4000_0000, 32'd2);
        push_seq(32'h4000_0000, 9, 10);
        for (int k = 0; k <= 10; k++) begin
            start     = (k == 0);
            cfg_valid = (k >= 1);
            cfg_tw    = 32'h2000_0000;
            cfg_burst = 32'd0;
            @(posedge clk_200M); #1;
            start = 1'b0;
            e = sb.pop_front();
            n_tests++;
            if ({sig_out, done, busy, cfg_ready, pulse_cnt} !== {e.s, e.d, e.b, ~e.b, e.pc}) begin
                n_fail++;
                $display("FAIL hs_hold k=%0d got sig/done/busy/rdy/cnt=%b/%b/%b/%b/%0d want %b/%b/%b/%b/%0d",
                         k, sig_out, done, busy, cfg_ready, pulse_cnt, e.s, e.d, e.b, ~e.b, e.pc);
            end
        end
        cfg_valid = 1'b0;
        push_seq(32'h2000_0000, 17, 18);
        for (int k = 0; k <= 18; k++) begin
            start = (k == 0);
            stop  = (k == 15);
            @(posedge clk_200M); #1;
            start = 1'b0;
            stop  = 1'b0;
            e = sb.pop_front();
            n_tests++;
            if ({sig_out, done, busy, cfg_ready, pulse_cnt} !== {e.s, e.d, e.b, ~e.b, e.pc}) begin
                n_fail++;
                $display("FAIL hs_new k=%0d got sig/done/busy/rdy/cnt=%b/%b/%b/%b/%0d want %b/%b/%b/%b/%0d",
                         k, sig_out, done, busy, cfg_ready, pulse_cnt, e.s, e.d, e.b, ~e.b, e.pc);
            end
        end
    endtask

    task automatic test_corner();
        exp_t e;
        // start+stop together: no run, no done, previous count held
        for (int k = 0; k <= 3; k++) begin
            e.s  = 1'b0;
            e.d  = 1'b0;
            e.b  = 1'b0;
            e.pc = 32'd2;
            sb.push_back(e);
        end
        for (int k = 0; k <= 3; k++) begin
            start = (k == 0);
            stop  = (k == 0);
            @(posedge clk_200M); #1;
            start = 1'b0;
            stop  = 1'b0;
            e = sb.pop_front();
            n_tests++;
            if ({sig_out, done, busy, cfg_ready, pulse_cnt} !== {e.s, e.d, e.b, ~e.b, e.pc}) begin
                n_fail++;
                $display("FAIL start_stop k=%0d got sig/done/busy/rdy/cnt=%b/%b/%b/%b/%0d want %b/%b/%b/%b/%0d",
                         k, sig_out, done, busy, cfg_ready, pulse_cnt, e.s, e.d, e.b, ~e.b, e.pc);
            end
        end
        do_cfg(32'd0, 32'd1);
        push_seq(32'd0, 20, 21);
        for (int k = 0; k <= 21; k++) begin
            start = (k == 0);
            stop  = (k == 20);
            @(posedge clk_200M); #1;
            start = 1'b0;
            stop  = 1'b0;
            e = sb.pop_front();
            n_tests++;
            if ({sig_out, done, busy, cfg_ready, pulse_cnt} !== {e.s, e.d, e.b, ~e.b, e.pc}) begin
                n_fail++;
                $display("FAIL tw_zero k=%0d got sig/done/busy/rdy/cnt=%b/%b/%b/%b/%0d want %b/%b/%b/%b/%0d",
                         k, sig_out, done, busy, cfg_ready, pulse_cnt, e.s, e.d, e.b, ~e.b, e.pc);
            end
        end
    endtask

    initial begin
        repeat (3) @(posedge clk_200M);
        #1;
        test_reset();
        test_burst();
        test_clamp();
        test_stop();
        test_handshake();
        test_corner();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
